// File: rtl/lc3b_types.sv
// lc3b_types: shared arbiter state encoding, default widths and LC-3b word/line types.
`default_nettype none

package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int ARB_NUM_MASTERS    = 2;
  localparam int ARB_ADDR_WIDTH     = 16;
  localparam int ARB_DATA_WIDTH     = 128;
  localparam int ARB_SEL_WIDTH      = 16;
  localparam int ARB_TIMEOUT_CYCLES = 255;

  typedef logic [ARB_ADDR_WIDTH-1:0] lc3b_word;
  typedef logic [ARB_DATA_WIDTH-1:0] lc3b_line;

endpackage

`default_nettype wire

// File: rtl/cache_arb_rr_pick.sv
// cache_arb_rr_pick: combinational round-robin pick, first requester after last_owner_i wins.
`default_nettype none

module cache_arb_rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_owner_i,
  output logic [NUM_MASTERS-1:0] grant_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    // Scan starts one past the previous owner so the last owner is checked last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IDX_W'((int'(last_owner_i) + k) % NUM_MASTERS);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin Wishbone arbiter from NUM_MASTERS L1 caches onto one L2 port.
// Optional busy watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
`default_nettype none

module cache_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_MASTERS    = ARB_NUM_MASTERS,
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int SEL_WIDTH      = ARB_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_m,
  output logic [DATA_WIDTH-1:0]            m_dat_s,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_rty,
  output logic                             s_cyc,
  output logic                             s_stb,
  output logic                             s_we,
  output logic [SEL_WIDTH-1:0]             s_sel,
  output logic [ADDR_WIDTH-1:0]            s_adr,
  output logic [DATA_WIDTH-1:0]            s_dat_m,
  input  logic [DATA_WIDTH-1:0]            s_dat_s,
  input  logic                             s_ack,
  input  logic                             s_rty,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  arb_state_t             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       last_q;
  logic                   busy_q;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       gidx;
  logic                   g_cyc, g_stb, g_we;
  logic                   active;
  logic                   timeout;

  assign req = m_cyc & m_stb;

  cache_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req_i        (req),
    .last_owner_i (last_q),
    .grant_o      (pick)
  );

  always_comb begin
    gidx    = '0;
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_m = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        gidx    = IDX_W'(i);
        g_cyc   = m_cyc[i];
        g_stb   = m_stb[i];
        g_we    = m_we[i];
        s_sel   = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
        s_adr   = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_m = m_dat_m[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !s_ack && !s_rty;
`else
  assign timeout = 1'b0;
`endif

  // Reset gates every strobe combinationally so nothing leaks while rst_n is low mid-BUSY.
  assign active  = rst_n && (state_q == BUSY);
  assign s_cyc   = active & g_cyc & ~timeout;
  assign s_stb   = active & g_cyc & g_stb & ~timeout;
  assign s_we    = active & g_cyc & g_we & ~timeout;
  assign m_ack   = active ? (grant_q & {NUM_MASTERS{s_ack}}) : '0;
  assign m_rty   = active ? (grant_q & {NUM_MASTERS{(s_rty & ~s_ack) | timeout}}) : '0;
  assign m_dat_s = s_dat_s;
  assign grant   = grant_q;
  assign busy    = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= pick;
            state_q <= BUSY;
            busy_q  <= 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUSY: begin
          if (s_ack || s_rty || timeout || !g_cyc) begin
            // An abort leaves last_q alone so the aborting master keeps its priority.
            if (g_cyc || s_ack || s_rty) begin
              last_q <= gidx;
            end
            state_q <= TURN;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for the two-master default configuration.
`default_nettype none

module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   m_cyc, m_stb, m_we;
  logic [31:0]  m_sel;
  logic [31:0]  m_adr;
  logic [255:0] m_dat_m;
  logic [127:0] m_dat_s;
  logic [1:0]   m_ack, m_rty;
  logic         s_cyc, s_stb, s_we;
  logic [15:0]  s_sel;
  logic [15:0]  s_adr;
  logic [127:0] s_dat_m;
  logic [127:0] s_dat_s;
  logic         s_ack, s_rty;
  logic [1:0]   grant;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] WDATA = 128'hDEAD_0123_4567_89AB_CDEF_0F1E_2D3C_BEEF;

  cache_arbiter u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_sel   (m_sel),
    .m_adr   (m_adr),
    .m_dat_m (m_dat_m),
    .m_dat_s (m_dat_s),
    .m_ack   (m_ack),
    .m_rty   (m_rty),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_sel   (s_sel),
    .s_adr   (s_adr),
    .s_dat_m (s_dat_m),
    .s_dat_s (s_dat_s),
    .s_ack   (s_ack),
    .s_rty   (s_rty),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0;
    m_dat_m = '0; s_dat_s = '0; s_ack = 1'b0; s_rty = 1'b0;
    tick(); tick();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_mack", m_ack, 2'b00);
    rst_n = 1'b1;
    tick();

    // Single read from m0
    m_cyc = 2'b01; m_stb = 2'b01; m_adr[15:0] = 16'h1230;
    #1;
    check("idle_scyc", s_cyc, 1'b0);
    tick();
    check("single_scyc", s_cyc, 1'b1);
    check("single_sstb", s_stb, 1'b1);
    check("single_sadr", s_adr, 16'h1230);
    check("single_swe", s_we, 1'b0);
    check("single_grant", grant, 2'b01);
    check("single_busy", busy, 1'b1);
    s_ack = 1'b1; s_dat_s = 128'h5555_AAAA;
    #1;
    check("single_mack", m_ack, 2'b01);
    check("single_mdats", m_dat_s, 128'h5555_AAAA);
    tick();
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    #1;
    check("single_turn_scyc", s_cyc, 1'b0);
    check("single_turn_grant", grant, 2'b00);
    check("single_turn_busy", busy, 1'b0);
    tick();
    check("single_idle_scyc", s_cyc, 1'b0);

    // Contention from reset: 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = {16'h2222, 16'h1111};
    for (int t = 0; t < 4; t++) begin
      tick();
      check("cont_grant", grant, exp_g[t]);
      check("cont_sadr", s_adr, exp_g[t][0] ? 16'h1111 : 16'h2222);
      s_ack = 1'b1;
      #1;
      check("cont_mack", m_ack, exp_g[t]);
      tick();
      s_ack = 1'b0;
      #1;
      check("cont_turn_grant", grant, 2'b00);
      check("cont_turn_scyc", s_cyc, 1'b0);
      tick();
    end

    // Write from m1, simultaneous ack+rty resolves as ack
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_sel = {16'hFFFF, 16'h0003}; m_adr = {16'hBEEF, 16'h0040};
    m_dat_m = {WDATA, 128'h0};
    tick();
    check("wr_grant", grant, 2'b10);
    check("wr_swe", s_we, 1'b1);
    check("wr_sdatm", s_dat_m, WDATA);
    check("wr_ssel", s_sel, 16'hFFFF);
    check("wr_sadr", s_adr, 16'hBEEF);
    tick();
    check("wr_hold_sdatm", s_dat_m, WDATA);
    check("wr_hold_mack", m_ack, 2'b00);
    s_ack = 1'b1; s_rty = 1'b1;
    #1;
    check("wr_mack", m_ack, 2'b10);
    check("wr_mrty_masked", m_rty, 2'b00);
    tick();
    s_ack = 1'b0; s_rty = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    tick();

    // Abort by m0, which keeps priority afterwards
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    check("abort_grant", grant, 2'b01);
    check("abort_scyc_pre", s_cyc, 1'b1);
    m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    check("abort_scyc", s_cyc, 1'b0);
    check("abort_sstb", s_stb, 1'b0);
    tick();
    check("abort_turn_grant", grant, 2'b00);
    tick();
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    check("abort_next_grant", grant, 2'b01);
    s_rty = 1'b1;
    #1;
    check("rty_mrty", m_rty, 2'b01);
    check("rty_mack", m_ack, 2'b00);
    tick();
    s_rty = 1'b0; m_cyc = '0; m_stb = '0;
    tick();

    // Reset asserted during an m1 transaction
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    tick();
    check("rstb_grant", grant, 2'b10);
    rst_n = 1'b0; s_ack = 1'b1;
    #1;
    check("rstb_scyc", s_cyc, 1'b0);
    check("rstb_swe", s_we, 1'b0);
    check("rstb_mack", m_ack, 2'b00);
    tick();
    check("rstb_grant_after", grant, 2'b00);
    check("rstb_busy_after", busy, 1'b0);
    rst_n = 1'b1; s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; m_we = '0;
    tick();
    check("rstb_first_grant", grant, 2'b01);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
